// File: rtl/vend_controller_pkg.sv
// Shared types for the vending controller: FSM state encoding and coin codes.
package vend_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_CHECK   = 3'd2,
    ST_VEND    = 3'd3,
    ST_CHANGE  = 3'd4
  } state_e;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_A    = 2'b01;
  localparam logic [1:0] COIN_B    = 2'b10;
  localparam logic [1:0] COIN_C    = 2'b11;

  function automatic logic is_busy(input state_e s);
    return (s == ST_CHECK) || (s == ST_VEND) || (s == ST_CHANGE);
  endfunction

endpackage

// File: rtl/vend_controller_if.sv
// Coin/selection/change handshake plus comparator hookup for the vending controller.
interface vend_controller_if #(parameter int N = 4);
  logic         coin_valid;
  logic [1:0]   coin_code;
  logic         sel_valid;
  logic [N-1:0] sel_price;
  logic         cancel;
  logic         change_ack;
  logic [N-1:0] cmp_out;
  logic [N-1:0] credit;
  logic [N-1:0] price;
  logic         dispense;
  logic         change_valid;
  logic [N-1:0] change_amt;
  logic         insufficient;
  logic         coin_reject;
  logic         busy;

  modport slave (
    input  coin_valid, coin_code, sel_valid, sel_price, cancel, change_ack, cmp_out,
    output credit, price, dispense, change_valid, change_amt, insufficient, coin_reject, busy
  );

  modport master (
    output coin_valid, coin_code, sel_valid, sel_price, cancel, change_ack, cmp_out,
    input  credit, price, dispense, change_valid, change_amt, insufficient, coin_reject, busy
  );
endinterface

// File: rtl/vend_controller_coin_decoder.sv
// Combinational coin code to unit value; code 00 means no coin.
module vend_controller_coin_decoder
  import vend_controller_pkg::*;
#(
  parameter int N       = 4,
  parameter int COIN_V1 = 1,
  parameter int COIN_V2 = 2,
  parameter int COIN_V3 = 5
) (
  input  logic [1:0]   coin_code,
  output logic [N-1:0] value,
  output logic         code_valid
);
  always_comb begin
    value      = '0;
    code_valid = 1'b1;
    unique case (coin_code)
      COIN_A:  value = N'(COIN_V1);
      COIN_B:  value = N'(COIN_V2);
      COIN_C:  value = N'(COIN_V3);
      default: code_valid = 1'b0;
    endcase
  end
endmodule

// File: rtl/vend_controller.sv
// Credit accumulation and vend sequencing FSM. Credit/price feed an external
// comparator whose eq/gt result is sampled back in CHECK.
module vend_controller
  import vend_controller_pkg::*;
#(
  parameter int N       = 4,
  parameter int COIN_V1 = 1,
  parameter int COIN_V2 = 2,
  parameter int COIN_V3 = 5
) (
  input logic              clk,
  input logic              rst_n,
  vend_controller_if.slave bus
);
  localparam logic [N-1:0] CMP_MASK = N'(3);

  state_e       state_q, state_d;
  logic [N-1:0] credit_q, credit_d;
  logic [N-1:0] price_q, price_d;
  logic [N-1:0] change_amt_q, change_amt_d;
  logic         change_valid_q, change_valid_d;
  logic         dispense_q, dispense_d;
  logic         insufficient_q, insufficient_d;
  logic         coin_reject_q, coin_reject_d;
  logic         busy_q, busy_d;

  logic [N-1:0] coin_val;
  logic         code_valid;
  logic         coin_ok;
  logic         cmp_hit;
  logic [N:0]   sum;
  logic [N-1:0] cred_new;
  logic [N-1:0] remainder;

  vend_controller_coin_decoder #(
    .N(N), .COIN_V1(COIN_V1), .COIN_V2(COIN_V2), .COIN_V3(COIN_V3)
  ) u_dec (
    .coin_code (bus.coin_code),
    .value     (coin_val),
    .code_valid(code_valid)
  );

  assign coin_ok   = bus.coin_valid & code_valid;
  assign cmp_hit   = |(bus.cmp_out & CMP_MASK);
  // Extra bit catches overflow past 2^N-1 so the coin can be refused.
  assign sum       = {1'b0, credit_q} + {1'b0, coin_val};
  assign remainder = credit_q - price_q;

  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    price_d        = price_q;
    change_amt_d   = change_amt_q;
    change_valid_d = change_valid_q;
    dispense_d     = 1'b0;
    insufficient_d = 1'b0;
    coin_reject_d  = 1'b0;
    cred_new       = credit_q;

    unique case (state_q)
      ST_IDLE, ST_COLLECT: begin
        if (coin_ok) begin
          if (sum[N]) begin
            coin_reject_d = 1'b1;
          end else begin
            cred_new = sum[N-1:0];
            state_d  = ST_COLLECT;
          end
        end
        credit_d = cred_new;
        // Same-cycle coin is already folded into cred_new for cancel/select.
        if (bus.cancel) begin
          if (cred_new != '0) begin
            state_d        = ST_CHANGE;
            change_amt_d   = cred_new;
            change_valid_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (bus.sel_valid && (bus.sel_price != '0)) begin
          price_d = bus.sel_price;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        coin_reject_d = coin_ok;
        if (cmp_hit) begin
          dispense_d = 1'b1;
          state_d    = ST_VEND;
        end else begin
          insufficient_d = 1'b1;
          price_d        = '0;
          state_d        = (credit_q != '0) ? ST_COLLECT : ST_IDLE;
        end
      end
      ST_VEND: begin
        coin_reject_d = coin_ok;
        credit_d      = remainder;
        price_d       = '0;
        if (remainder != '0) begin
          state_d        = ST_CHANGE;
          change_amt_d   = remainder;
          change_valid_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CHANGE: begin
        coin_reject_d = coin_ok;
        if (bus.change_ack) begin
          credit_d       = '0;
          change_amt_d   = '0;
          change_valid_d = 1'b0;
          state_d        = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = is_busy(state_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      credit_q       <= '0;
      price_q        <= '0;
      change_amt_q   <= '0;
      change_valid_q <= 1'b0;
      dispense_q     <= 1'b0;
      insufficient_q <= 1'b0;
      coin_reject_q  <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      price_q        <= price_d;
      change_amt_q   <= change_amt_d;
      change_valid_q <= change_valid_d;
      dispense_q     <= dispense_d;
      insufficient_q <= insufficient_d;
      coin_reject_q  <= coin_reject_d;
      busy_q         <= busy_d;
    end
  end

  assign bus.credit       = credit_q;
  assign bus.price        = price_q;
  assign bus.dispense     = dispense_q;
  assign bus.change_valid = change_valid_q;
  assign bus.change_amt   = change_amt_q;
  assign bus.insufficient = insufficient_q;
  assign bus.coin_reject  = coin_reject_q;
  assign bus.busy         = busy_q;
endmodule
